// File: rtl/control_unit.sv
// RedCPU sequencer: latches a 16-bit command in FETCH and walks OP1/OP2/EXEC/WB,
// decoding one datapath strobe per cycle from the current state and latched IR.
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] command,
    output logic        write_reg,
    output logic [3:0]  reg_addr,
    output logic        write_op1,
    output logic        write_op2,
    output logic [2:0]  alu_act,
    output logic        save_alu_res,
    output logic [1:0]  in_data
);

    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] OP1   = 3'd1;
    localparam logic [2:0] OP2   = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] WB    = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [15:0] ir;
    logic [3:0]  op;

    assign op = ir[15:12];

    // FETCH routes on the incoming opcode, later states on the latched one.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH: begin
                case (command[15:12])
                    4'h1, 4'h2: state_next = WB;
                    4'h3:       state_next = OP1;
                    default:    state_next = command[15] ? OP1 : FETCH;
                endcase
            end
            OP1:     state_next = (op == 4'h3) ? WB : OP2;
            OP2:     state_next = EXEC;
            EXEC:    state_next = WB;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            if (state == FETCH)
                ir <= command;
        end
    end

    // Reset forces FETCH with IR=0, so every output falls to 0 without extra gating.
    always_comb begin
        write_reg    = 1'b0;
        reg_addr     = 4'h0;
        write_op1    = 1'b0;
        write_op2    = 1'b0;
        alu_act      = 3'd0;
        save_alu_res = 1'b0;
        in_data      = 2'd0;
        case (state)
            OP1: begin
                reg_addr  = ir[7:4];
                write_op1 = 1'b1;
            end
            OP2: begin
                reg_addr  = ir[3:0];
                write_op2 = 1'b1;
            end
            EXEC: begin
                alu_act      = op[2:0];
                save_alu_res = 1'b1;
            end
            WB: begin
                reg_addr  = ir[11:8];
                write_reg = 1'b1;
                in_data   = op[3] ? 2'd0 : op[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: steps one clock per instruction cycle and
// compares the full output bundle against hand-computed values.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] command;
    logic        write_reg;
    logic [3:0]  reg_addr;
    logic        write_op1;
    logic        write_op2;
    logic [2:0]  alu_act;
    logic        save_alu_res;
    logic [1:0]  in_data;

    int checks = 0;
    int fails  = 0;
    bit count_en = 1'b0;
    int cnt_wr = 0, cnt_op1 = 0, cnt_op2 = 0, cnt_save = 0, multi_strobe = 0;

    control_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .command(command),
        .write_reg(write_reg),
        .reg_addr(reg_addr),
        .write_op1(write_op1),
        .write_op2(write_op2),
        .alu_act(alu_act),
        .save_alu_res(save_alu_res),
        .in_data(in_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe tally on the falling edge, midway through each state.
    always @(negedge clk) begin
        if (rst_n && (int'(write_reg) + int'(write_op1) + int'(write_op2) + int'(save_alu_res)) > 1)
            multi_strobe++;
        if (count_en) begin
            cnt_wr   += int'(write_reg);
            cnt_op1  += int'(write_op1);
            cnt_op2  += int'(write_op2);
            cnt_save += int'(save_alu_res);
        end
    end

    function automatic logic [12:0] packOut(input logic wr, input logic [3:0] addr, input logic o1,
                                            input logic o2, input logic [2:0] act, input logic sv,
                                            input logic [1:0] ind);
        return {wr, addr, o1, o2, act, sv, ind};
    endfunction

    task automatic applyStimulus(input logic [15:0] cmd);
        command = cmd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [12:0] expected);
        logic [12:0] observed;
        observed = {write_reg, reg_addr, write_op1, write_op2, alu_act, save_alu_res, in_data};
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %013b expected %013b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    localparam logic [12:0] IDLE = 13'd0;

    initial begin
        rst_n   = 1'b0;
        command = 16'h0000;
        #2;
        checkOutput("reset_initial", IDLE);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("after_release", IDLE);

        // LDI 0x15A7: WB next cycle, then back to FETCH
        applyStimulus(16'h15A7);
        checkOutput("ldi_wb", packOut(1'b1, 4'd5, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1));
        applyStimulus(16'h0000);
        checkOutput("ldi_fetch", IDLE);

        // ALU 0xA312 with command noise mid-instruction
        applyStimulus(16'hA312);
        checkOutput("alu_op1", packOut(1'b0, 4'd1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0));
        applyStimulus(16'hFFFF);
        checkOutput("alu_op2", packOut(1'b0, 4'd2, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0));
        applyStimulus(16'h0000);
        checkOutput("alu_exec", packOut(1'b0, 4'd0, 1'b0, 1'b0, 3'd2, 1'b1, 2'd0));
        applyStimulus(16'h1234);
        checkOutput("alu_wb", packOut(1'b1, 4'd3, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0));
        applyStimulus(16'h0000);
        checkOutput("alu_fetch", IDLE);

        // MOV 0x3740
        applyStimulus(16'h3740);
        checkOutput("mov_op1", packOut(1'b0, 4'd4, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0));
        applyStimulus(16'h0000);
        checkOutput("mov_wb", packOut(1'b1, 4'd7, 1'b0, 1'b0, 3'd0, 1'b0, 2'd3));
        applyStimulus(16'h0000);
        checkOutput("mov_fetch", IDLE);

        // NOP / reserved opcodes stay in FETCH every cycle
        applyStimulus(16'h0000);
        checkOutput("nop_0000", IDLE);
        applyStimulus(16'h5FFF);
        checkOutput("nop_5fff", IDLE);
        applyStimulus(16'h15A7);
        checkOutput("after_nop_ldi_wb", packOut(1'b1, 4'd5, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1));
        applyStimulus(16'h0000);
        checkOutput("after_nop_fetch", IDLE);

        // Back-to-back IN 0x2900 then ALU 0xF123, command toggled mid-ALU
        count_en = 1'b1;
        applyStimulus(16'h2900);
        checkOutput("in_wb", packOut(1'b1, 4'd9, 1'b0, 1'b0, 3'd0, 1'b0, 2'd2));
        applyStimulus(16'hF123);
        checkOutput("in_fetch", IDLE);
        applyStimulus(16'hF123);
        checkOutput("b2b_op1", packOut(1'b0, 4'd2, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0));
        applyStimulus(16'h1500);
        checkOutput("b2b_op2", packOut(1'b0, 4'd3, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0));
        applyStimulus(16'h2900);
        checkOutput("b2b_exec", packOut(1'b0, 4'd0, 1'b0, 1'b0, 3'd7, 1'b1, 2'd0));
        applyStimulus(16'h3000);
        checkOutput("b2b_wb", packOut(1'b1, 4'd1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0));
        applyStimulus(16'h0000);
        checkOutput("b2b_fetch", IDLE);
        @(negedge clk);
        count_en = 1'b0;
        checkCount("b2b_write_reg_count", cnt_wr, 2);
        checkCount("b2b_write_op1_count", cnt_op1, 1);
        checkCount("b2b_write_op2_count", cnt_op2, 1);
        checkCount("b2b_save_count", cnt_save, 1);

        // Reset asserted mid-EXEC clears outputs immediately
        @(posedge clk);
        #1;
        applyStimulus(16'hA312);
        applyStimulus(16'h0000);
        applyStimulus(16'h0000);
        checkOutput("rst_pre_exec", packOut(1'b0, 4'd0, 1'b0, 1'b0, 3'd2, 1'b1, 2'd0));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_exec", IDLE);
        @(posedge clk);
        #1;
        checkOutput("rst_held", IDLE);
        #2;
        rst_n = 1'b1;
        applyStimulus(16'h15A7);
        checkOutput("rst_first_fetch", packOut(1'b1, 4'd5, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1));
        applyStimulus(16'h0000);
        checkOutput("rst_back_fetch", IDLE);

        checkCount("single_strobe", multi_strobe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
